gpr_scoreboard: RTL and testbench

Issue-side pending-write scoreboard for the MIPS pipeline. It records every in-flight long-latency register write: loads that wait on memory and multi-cycle MULT/DIV results to HI/LO. It stalls decode when an issuing instruction reads or rewrites a destination that is still pending. Short-latency producers are resolved by the existing forwarding path; this block covers only writers whose result arrives an unknown number of cycles after issue.

---
 rtl/gpr_scoreboard_pkg.sv | 46 ++++
 rtl/gpr_scoreboard_if.sv | 29 ++
 rtl/gpr_scoreboard_src_check.sv | 22 ++
 rtl/gpr_scoreboard.sv | 127 ++++++++++++
 tb/tb_gpr_scoreboard.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpr_scoreboard_pkg.sv
// Shared pipeline typedefs plus the scoreboard's pending-vector type and the
// helper that maps a writeback destination onto that vector.
package gpr_scoreboard_pkg;

    typedef enum logic [1:0] {
        NONE_EN = 2'd0,
        GPR_EN  = 2'd1,
        HI_EN   = 2'd2,
        LO_EN   = 2'd3
    } src_en_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        src_en_t    rs_en;
        src_en_t    rt_en;
    } gpr_ctrl_t;

    typedef struct packed {
        logic       wr_en;
        logic [4:0] wr_gpr;
        logic       wr_hi;
        logic       wr_lo;
    } wb_ctrl_t;

    typedef struct packed {
        logic [31:0] gpr;
        logic        hi;
        logic        lo;
    } sb_vec_t;

    localparam int WDOG_W = 11;

    // r0 is hardwired, so a write to it never maps to a pending bit.
    function automatic sb_vec_t wb_to_vec(input wb_ctrl_t wb);
        sb_vec_t v;
        v = '0;
        if (wb.wr_en && (wb.wr_gpr != 5'd0)) begin
            v.gpr[wb.wr_gpr] = 1'b1;
        end
        v.hi = wb.wr_hi;
        v.lo = wb.wr_lo;
        return v;
    endfunction

endpackage

// File: rtl/gpr_scoreboard_if.sv
// Issue/completion handshake and status bundle between decode and the
// pending-write scoreboard.
interface gpr_scoreboard_if;
    import gpr_scoreboard_pkg::*;

    logic        issue_valid;
    gpr_ctrl_t   gpr_ctrl;
    wb_ctrl_t    issue_wb;
    logic        issue_long;
    logic        cmpl_valid;
    wb_ctrl_t    cmpl_wb;
    logic        stall;
    logic [31:0] pend_gpr;
    logic        pend_hi;
    logic        pend_lo;
    logic [3:0]  outstanding;
    logic        sb_err;

    modport master (
        output issue_valid, gpr_ctrl, issue_wb, issue_long, cmpl_valid, cmpl_wb,
        input  stall, pend_gpr, pend_hi, pend_lo, outstanding, sb_err
    );

    modport slave (
        input  issue_valid, gpr_ctrl, issue_wb, issue_long, cmpl_valid, cmpl_wb,
        output stall, pend_gpr, pend_hi, pend_lo, outstanding, sb_err
    );

endinterface

// File: rtl/gpr_scoreboard_src_check.sv
// Combinational lookup of one instruction source against the effective
// (completion-bypassed) pending vector.
module sb_src_check
    import gpr_scoreboard_pkg::*;
(
    input  logic [4:0] sel,
    input  src_en_t    en,
    input  sb_vec_t    eff_pend,
    output logic       hit
);

    always_comb begin
        hit = 1'b0;
        case (en)
            GPR_EN:  hit = (sel != 5'd0) && eff_pend.gpr[sel];
            HI_EN:   hit = eff_pend.hi;
            LO_EN:   hit = eff_pend.lo;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard for long-latency GPR/HI/LO writers; stalls decode on
// RAW/WAW hazards or a full table. Define SCOREBOARD_WDOG_EN for the idle watchdog.
module gpr_scoreboard
    import gpr_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int WDOG_LIMIT      = 1023
) (
    input  logic clk,
    input  logic rst,
    gpr_scoreboard_if.slave sb
);

    if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 15)) begin : g_bad_max
        $error("gpr_scoreboard: MAX_OUTSTANDING must be 1..15");
    end
    if ((WDOG_LIMIT < 1) || (WDOG_LIMIT > (1 << WDOG_W) - 1)) begin : g_bad_wdog
        $error("gpr_scoreboard: WDOG_LIMIT out of range for the idle counter");
    end

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    sb_vec_t    pend_q;
    sb_vec_t    pend_next;
    sb_vec_t    clr_vec;
    sb_vec_t    eff_pend;
    sb_vec_t    dst_vec;
    logic [3:0] outstanding_q;
    logic [3:0] outstanding_next;
    logic       sb_err_q;
    logic       rs_hit;
    logic       rt_hit;
    logic       waw_hit;
    logic       full;
    logic       fire;
    logic       cmpl_legal;
    logic       cmpl_illegal;
    logic       wdog_trip;

    // A completing result is forwarded, so its bits no longer block issue this cycle.
    assign clr_vec  = sb.cmpl_valid ? wb_to_vec(sb.cmpl_wb) : '0;
    assign eff_pend = pend_q & ~clr_vec;
    assign dst_vec  = wb_to_vec(sb.issue_wb);

    sb_src_check u_rs_check (
        .sel      (sb.gpr_ctrl.rs),
        .en       (sb.gpr_ctrl.rs_en),
        .eff_pend (eff_pend),
        .hit      (rs_hit)
    );

    sb_src_check u_rt_check (
        .sel      (sb.gpr_ctrl.rt),
        .en       (sb.gpr_ctrl.rt_en),
        .eff_pend (eff_pend),
        .hit      (rt_hit)
    );

    assign cmpl_legal   = sb.cmpl_valid && ((clr_vec & pend_q) != '0) && (outstanding_q != 4'd0);
    assign cmpl_illegal = sb.cmpl_valid && !cmpl_legal;

    // Only a legal completion frees a slot; counting an illegal one would overflow the table.
    assign waw_hit  = (dst_vec & eff_pend) != '0;
    assign full     = sb.issue_long && (outstanding_q == MAX_OUT) && !cmpl_legal;
    assign sb.stall = sb.issue_valid && (rs_hit || rt_hit || waw_hit || full);
    assign fire     = sb.issue_valid && !sb.stall && sb.issue_long;

    // Clear first, then set, so a same-cycle re-issue of the completing register wins.
    always_comb begin
        pend_next = pend_q;
        if (cmpl_legal) begin
            pend_next = pend_next & ~clr_vec;
        end
        if (fire) begin
            pend_next = pend_next | dst_vec;
        end
        pend_next.gpr[0] = 1'b0;
        outstanding_next = outstanding_q + {3'd0, fire} - {3'd0, cmpl_legal};
    end

`ifdef SCOREBOARD_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_LIMIT);

    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_next;

    always_comb begin
        wdog_next = wdog_q;
        if ((outstanding_q == 4'd0) || sb.cmpl_valid) begin
            wdog_next = '0;
        end else if (wdog_q != WDOG_LIM) begin
            wdog_next = wdog_q + 1'b1;
        end
    end

    assign wdog_trip = (wdog_next == WDOG_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_next;
        end
    end
`else
    assign wdog_trip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q        <= '0;
            outstanding_q <= 4'd0;
            sb_err_q      <= 1'b0;
        end else begin
            pend_q        <= pend_next;
            outstanding_q <= outstanding_next;
            sb_err_q      <= sb_err_q || cmpl_illegal || wdog_trip;
        end
    end

    assign sb.pend_gpr    = pend_q.gpr;
    assign sb.pend_hi     = pend_q.hi;
    assign sb.pend_lo     = pend_q.lo;
    assign sb.outstanding = outstanding_q;
    assign sb.sb_err      = sb_err_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed self-checking bench for gpr_scoreboard; the watchdog scenario is
// selected by SCOREBOARD_WDOG_EN to match the RTL build.
module tb_gpr_scoreboard;
    import gpr_scoreboard_pkg::*;

`ifdef SCOREBOARD_WDOG_EN
    localparam int WDOG = 8;
`else
    localparam int WDOG = 1023;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gpr_scoreboard_if sb_if ();

    gpr_scoreboard #(
        .MAX_OUTSTANDING (4),
        .WDOG_LIMIT      (WDOG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic wb_ctrl_t gpr_wb(input logic [4:0] r);
        wb_ctrl_t w;
        w        = '0;
        w.wr_en  = 1'b1;
        w.wr_gpr = r;
        return w;
    endfunction

    function automatic wb_ctrl_t hilo_wb();
        wb_ctrl_t w;
        w       = '0;
        w.wr_hi = 1'b1;
        w.wr_lo = 1'b1;
        return w;
    endfunction

    task automatic applyStimulus(input logic iv, input logic [4:0] rs, input src_en_t rs_en,
                                 input logic [4:0] rt, input src_en_t rt_en, input wb_ctrl_t wb,
                                 input logic lng, input logic cv, input wb_ctrl_t cwb);
        sb_if.issue_valid    = iv;
        sb_if.gpr_ctrl.rs    = rs;
        sb_if.gpr_ctrl.rs_en = rs_en;
        sb_if.gpr_ctrl.rt    = rt;
        sb_if.gpr_ctrl.rt_en = rt_en;
        sb_if.issue_wb       = wb;
        sb_if.issue_long     = lng;
        sb_if.cmpl_valid     = cv;
        sb_if.cmpl_wb        = cwb;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 5'd0, NONE_EN, 5'd0, NONE_EN, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkStall(input string tag, input logic exp);
        #1;
        checkOutput({tag, ".stall"}, {63'd0, sb_if.stall}, {63'd0, exp});
    endtask

    task automatic checkState(input string tag, input logic [31:0] pend, input logic hi,
                              input logic lo, input logic [3:0] outs, input logic err);
        checkOutput({tag, ".pend_gpr"}, {32'd0, sb_if.pend_gpr}, {32'd0, pend});
        checkOutput({tag, ".pend_hi"}, {63'd0, sb_if.pend_hi}, {63'd0, hi});
        checkOutput({tag, ".pend_lo"}, {63'd0, sb_if.pend_lo}, {63'd0, lo});
        checkOutput({tag, ".outstanding"}, {60'd0, sb_if.outstanding}, {60'd0, outs});
        checkOutput({tag, ".sb_err"}, {63'd0, sb_if.sb_err}, {63'd0, err});
    endtask

    task automatic pulseReset();
        idleInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkState("reset", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("reset.stall", {63'd0, sb_if.stall}, 64'd0);

        // Load to r5, dependent ADD stalls until the completion cycle.
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, gpr_wb(5'd5), 1'b1, 1'b0, '0);
        checkStall("ld5.issue", 1'b0);
        tick();
        checkState("ld5.set", 32'h0000_0020, 1'b0, 1'b0, 4'd1, 1'b0);
        applyStimulus(1'b1, 5'd5, GPR_EN, 5'd0, NONE_EN, gpr_wb(5'd7), 1'b0, 1'b0, '0);
        checkStall("add.raw", 1'b1);
        tick();
        checkState("add.hold", 32'h0000_0020, 1'b0, 1'b0, 4'd1, 1'b0);
        applyStimulus(1'b1, 5'd5, GPR_EN, 5'd0, NONE_EN, gpr_wb(5'd7), 1'b0, 1'b1, gpr_wb(5'd5));
        checkStall("add.bypass", 1'b0);
        tick();
        checkState("ld5.done", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0);

        // rt RAW and WAW against a pending r10.
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, gpr_wb(5'd10), 1'b1, 1'b0, '0);
        tick();
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, gpr_wb(5'd10), 1'b0, 1'b0, '0);
        checkStall("waw.r10", 1'b1);
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd10, GPR_EN, gpr_wb(5'd11), 1'b0, 1'b0, '0);
        checkStall("raw.rt10", 1'b1);
        applyStimulus(1'b0, 5'd0, NONE_EN, 5'd0, NONE_EN, '0, 1'b0, 1'b1, gpr_wb(5'd10));
        tick();
        checkState("r10.done", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0);

        // MULT to HI/LO, MFHI waits, then issues in the completion cycle.
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, hilo_wb(), 1'b1, 1'b0, '0);
        checkStall("mult.issue", 1'b0);
        tick();
        checkState("mult.set", 32'h0, 1'b1, 1'b1, 4'd1, 1'b0);
        applyStimulus(1'b1, 5'd0, HI_EN, 5'd0, NONE_EN, gpr_wb(5'd8), 1'b0, 1'b0, '0);
        checkStall("mfhi.raw", 1'b1);
        applyStimulus(1'b1, 5'd0, LO_EN, 5'd0, NONE_EN, gpr_wb(5'd8), 1'b0, 1'b0, '0);
        checkStall("mflo.raw", 1'b1);
        tick();
        applyStimulus(1'b1, 5'd0, HI_EN, 5'd0, NONE_EN, gpr_wb(5'd8), 1'b0, 1'b1, hilo_wb());
        checkStall("mfhi.bypass", 1'b0);
        tick();
        checkState("mult.done", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Fill the table, then a fifth long op.
        for (int r = 1; r <= 4; r++) begin
            applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, gpr_wb(5'(r)), 1'b1, 1'b0, '0);
            tick();
        end
        checkState("fill", 32'h0000_001E, 1'b0, 1'b0, 4'd4, 1'b0);
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, gpr_wb(5'd6), 1'b1, 1'b0, '0);
        checkStall("full.r6", 1'b1);
        tick();
        checkState("full.hold", 32'h0000_001E, 1'b0, 1'b0, 4'd4, 1'b0);
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, gpr_wb(5'd6), 1'b1, 1'b1, gpr_wb(5'd1));
        checkStall("full.swap", 1'b0);
        tick();
        checkState("full.swap", 32'h0000_005C, 1'b0, 1'b0, 4'd4, 1'b0);
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, gpr_wb(5'd2), 1'b1, 1'b1, gpr_wb(5'd2));
        checkStall("setwins", 1'b0);
        tick();
        checkState("setwins", 32'h0000_005C, 1'b0, 1'b0, 4'd4, 1'b0);

        // Asynchronous reset between edges.
        idleInputs();
        rst = 1'b1;
        #1;
        checkState("async.rst", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        rst = 1'b0;

        // Long write to r0 counts but never marks a bit.
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, gpr_wb(5'd0), 1'b1, 1'b0, '0);
        checkStall("r0.issue", 1'b0);
        tick();
        checkState("r0.set", 32'h0, 1'b0, 1'b0, 4'd1, 1'b0);
        applyStimulus(1'b1, 5'd0, GPR_EN, 5'd0, GPR_EN, gpr_wb(5'd12), 1'b0, 1'b0, '0);
        checkStall("r0.read", 1'b0);
        tick();
        checkState("r0.after", 32'h0, 1'b0, 1'b0, 4'd1, 1'b0);
        pulseReset();

        // Completion of a register that is not pending.
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, gpr_wb(5'd3), 1'b1, 1'b0, '0);
        tick();
        checkState("ld3", 32'h0000_0008, 1'b0, 1'b0, 4'd1, 1'b0);
        applyStimulus(1'b0, 5'd0, NONE_EN, 5'd0, NONE_EN, '0, 1'b0, 1'b1, gpr_wb(5'd9));
        tick();
        checkState("illegal.r9", 32'h0000_0008, 1'b0, 1'b0, 4'd1, 1'b1);
        idleInputs();
        rst = 1'b1;
        #1;
        checkState("err.rst", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, NONE_EN, 5'd0, NONE_EN, '0, 1'b0, 1'b1, gpr_wb(5'd3));
        tick();
        checkState("stale.cmpl", 32'h0, 1'b0, 1'b0, 4'd0, 1'b1);
        pulseReset();

`ifdef SCOREBOARD_WDOG_EN
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, gpr_wb(5'd4), 1'b1, 1'b0, '0);
        tick();
        idleInputs();
        repeat (7) tick();
        checkState("wdog.7", 32'h0000_0010, 1'b0, 1'b0, 4'd1, 1'b0);
        tick();
        checkState("wdog.8", 32'h0000_0010, 1'b0, 1'b0, 4'd1, 1'b1);
        rst = 1'b1;
        #1;
        checkState("wdog.rst", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        rst = 1'b0;
`else
        applyStimulus(1'b1, 5'd0, NONE_EN, 5'd0, NONE_EN, gpr_wb(5'd4), 1'b1, 1'b0, '0);
        tick();
        idleInputs();
        repeat (40) tick();
        checkState("nowdog.idle", 32'h0000_0010, 1'b0, 1'b0, 4'd1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
